// File: rtl/frame_buffer_multi.sv
// Single-clock N-buffer (double or triple) frame store between a pixel writer and a display reader.
// Buffer roles rotate on frame-complete / frame-start handshakes; pixel reads have one cycle of latency.
module frame_buffer_multi #(
    parameter int PIX_BITS   = 2,
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 144,
    parameter int COORD_BITS = 9,
    parameter int NUM_BUFS   = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [COORD_BITS-1:0] wr_x,
    input  logic [COORD_BITS-1:0] wr_y,
    input  logic [PIX_BITS-1:0]   wr_data,
    input  logic                  wr_frame_done,
    output logic                  wr_ready,
    input  logic [COORD_BITS-1:0] rd_x,
    input  logic [COORD_BITS-1:0] rd_y,
    input  logic                  rd_frame_start,
    output logic [PIX_BITS-1:0]   rd_data,
    output logic                  rd_valid,
    output logic [1:0]            wr_buf_idx,
    output logic [1:0]            rd_buf_idx,
    output logic [7:0]            frames_dropped
);

    localparam int DEPTH     = WIDTH * HEIGHT;
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam bit IS_TRIPLE = (NUM_BUFS == 3);

    if ((NUM_BUFS != 2) && (NUM_BUFS != 3)) begin : g_bad_num_bufs
        $error("frame_buffer_multi: NUM_BUFS must be 2 or 3");
    end

    logic [1:0]          rd_buf_r, wr_buf_r, spare_r;
    logic                pending_r, wr_ready_r, rd_valid_r;
    logic [PIX_BITS-1:0] rd_data_r;
    logic [7:0]          dropped_r;

    logic [1:0]          rd_buf_s, wr_buf_s, spare_s;
    logic                pending_s, wr_ready_s;
    logic [7:0]          dropped_s;

    logic                 wr_in_range_s, rd_in_range_s, wr_we_s;
    logic [ADDR_BITS-1:0] wr_addr_s, rd_addr_s;
    logic [PIX_BITS-1:0]  rd_word_s [NUM_BUFS];
    logic [PIX_BITS-1:0]  rd_sel_s;

    assign wr_in_range_s = (wr_x < COORD_BITS'(WIDTH)) && (wr_y < COORD_BITS'(HEIGHT));
    assign rd_in_range_s = (rd_x < COORD_BITS'(WIDTH)) && (rd_y < COORD_BITS'(HEIGHT));
    assign wr_addr_s     = ADDR_BITS'(wr_y) * ADDR_BITS'(WIDTH) + ADDR_BITS'(wr_x);
    assign rd_addr_s     = ADDR_BITS'(rd_y) * ADDR_BITS'(WIDTH) + ADDR_BITS'(rd_x);
    // Writes issued while reset is asserted must not disturb the stored frames.
    assign wr_we_s       = reset_n & wr_en & wr_ready_r & wr_in_range_s;

    for (genvar g = 0; g < NUM_BUFS; g++) begin : g_bank
        logic [PIX_BITS-1:0] mem_r [DEPTH];

        // Pixel storage write port; contents deliberately have no reset.
        always_ff @(posedge clock) begin
            if (wr_we_s && (wr_buf_r == 2'(g))) begin
                mem_r[wr_addr_s] <= wr_data;
            end
        end

        assign rd_word_s[g] = mem_r[rd_addr_s];
    end

    // Select the word of the buffer currently owned by the reader.
    always_comb begin
        rd_sel_s = {PIX_BITS{1'b0}};
        for (int i = 0; i < NUM_BUFS; i++) begin
            rd_sel_s = rd_sel_s | ({PIX_BITS{rd_buf_r == 2'(i)}} & rd_word_s[i]);
        end
    end

    // Role rotation: frame-done is applied first, frame-start then acts on that result.
    always_comb begin
        rd_buf_s  = rd_buf_r;
        wr_buf_s  = wr_buf_r;
        spare_s   = spare_r;
        pending_s = pending_r;
        dropped_s = dropped_r;
        if (IS_TRIPLE) begin
            if (wr_frame_done) begin
                // Same rotation either way; an already-pending frame is lost.
                wr_buf_s  = spare_r;
                spare_s   = wr_buf_r;
                pending_s = 1'b1;
                if (pending_r && (dropped_r != 8'hFF)) begin
                    dropped_s = dropped_r + 8'd1;
                end else begin
                    dropped_s = dropped_r;
                end
            end else begin
                pending_s = pending_r;
            end
            if (rd_frame_start && pending_s) begin
                rd_buf_s  = spare_s;
                spare_s   = rd_buf_r;
                pending_s = 1'b0;
            end else begin
                rd_buf_s  = rd_buf_r;
            end
        end else begin
            if (wr_frame_done) begin
                pending_s = 1'b1;
            end else begin
                pending_s = pending_r;
            end
            if (rd_frame_start && pending_s) begin
                rd_buf_s  = wr_buf_r;
                wr_buf_s  = rd_buf_r;
                pending_s = 1'b0;
            end else begin
                rd_buf_s  = rd_buf_r;
            end
        end
        wr_ready_s = IS_TRIPLE ? 1'b1 : ~pending_s;
    end

    // Role, flag and counter registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_buf_r   <= 2'd0;
            wr_buf_r   <= 2'd1;
            spare_r    <= 2'd2;
            pending_r  <= 1'b0;
            wr_ready_r <= 1'b1;
            dropped_r  <= 8'd0;
        end else begin
            rd_buf_r   <= rd_buf_s;
            wr_buf_r   <= wr_buf_s;
            spare_r    <= spare_s;
            pending_r  <= pending_s;
            wr_ready_r <= wr_ready_s;
            dropped_r  <= dropped_s;
        end
    end

    // Registered read port; the index sampled here is the pre-swap reader buffer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_data_r  <= {PIX_BITS{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_data_r  <= rd_in_range_s ? rd_sel_s : {PIX_BITS{1'b0}};
            rd_valid_r <= rd_in_range_s;
        end
    end

    assign wr_ready       = wr_ready_r;
    assign rd_data        = rd_data_r;
    assign rd_valid       = rd_valid_r;
    assign wr_buf_idx     = wr_buf_r;
    assign rd_buf_idx     = rd_buf_r;
    assign frames_dropped = dropped_r;

endmodule

// File: tb/tb_frame_buffer_multi.sv
// Directed self-checking bench: a triple-buffer and a double-buffer instance driven with shared stimulus.
module tb_frame_buffer_multi;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [8:0] wr_x = 9'd0, wr_y = 9'd0;
    logic [1:0] wr_data = 2'd0;
    logic       wr_frame_done = 1'b0;
    logic [8:0] rd_x = 9'd200, rd_y = 9'd10;
    logic       rd_frame_start = 1'b0;

    logic       t_wr_ready, t_rd_valid, d_wr_ready, d_rd_valid;
    logic [1:0] t_rd_data, t_wr_buf, t_rd_buf, d_rd_data, d_wr_buf, d_rd_buf;
    logic [7:0] t_dropped, d_dropped;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    frame_buffer_multi #(.NUM_BUFS(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .wr_frame_done(wr_frame_done), .wr_ready(t_wr_ready),
        .rd_x(rd_x), .rd_y(rd_y), .rd_frame_start(rd_frame_start), .rd_data(t_rd_data),
        .rd_valid(t_rd_valid), .wr_buf_idx(t_wr_buf), .rd_buf_idx(t_rd_buf),
        .frames_dropped(t_dropped)
    );

    frame_buffer_multi #(.NUM_BUFS(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .wr_frame_done(wr_frame_done), .wr_ready(d_wr_ready),
        .rd_x(rd_x), .rd_y(rd_y), .rd_frame_start(rd_frame_start), .rd_data(d_rd_data),
        .rd_valid(d_rd_valid), .wr_buf_idx(d_wr_buf), .rd_buf_idx(d_rd_buf),
        .frames_dropped(d_dropped)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic write_px(input int x, input int y, input logic [1:0] d);
        wr_en = 1'b1; wr_x = 9'(x); wr_y = 9'(y); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse(input logic done, input logic start);
        wr_frame_done = done; rd_frame_start = start;
        step();
        wr_frame_done = 1'b0; rd_frame_start = 1'b0;
    endtask

    task automatic read_px(input int x, input int y);
        rd_x = 9'(x); rd_y = 9'(y);
        step();
        rd_x = 9'd200; rd_y = 9'd10;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 6;
        if (t_rd_buf !== 2'd0) begin n_fail++; $display("FAIL reset_rd_buf: got %0d want 0", t_rd_buf); end
        if (t_wr_buf !== 2'd1) begin n_fail++; $display("FAIL reset_wr_buf: got %0d want 1", t_wr_buf); end
        if (t_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %0b want 1", t_wr_ready); end
        if (t_rd_data !== 2'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d want 0", t_rd_data); end
        if (t_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0b want 0", t_rd_valid); end
        if (t_dropped !== 8'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", t_dropped); end
    endtask

    task automatic test_basic();
        do_reset();
        write_px(5, 3, 2'd2);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        rd_x = 9'd5; rd_y = 9'd3;
        #1;
        n_cmp++;
        if (t_rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency: got valid %0b want 0 before edge", t_rd_valid); end
        step();
        rd_x = 9'd200; rd_y = 9'd10;
        n_cmp += 3;
        if (t_rd_data !== 2'd2) begin n_fail++; $display("FAIL basic_data: got %0d want 2", t_rd_data); end
        if (t_rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", t_rd_valid); end
        if (t_rd_buf !== 2'd1) begin n_fail++; $display("FAIL basic_rd_buf: got %0d want 1", t_rd_buf); end
    endtask

    task automatic test_triple_drop();
        do_reset();
        write_px(0, 0, 2'd1);
        pulse(1'b1, 1'b0);
        write_px(0, 0, 2'd2);
        pulse(1'b1, 1'b0);
        // Third marker written in the same cycle as frame-done lands in the pre-swap buffer.
        wr_en = 1'b1; wr_x = 9'd0; wr_y = 9'd0; wr_data = 2'd3;
        pulse(1'b1, 1'b0);
        wr_en = 1'b0;
        n_cmp++;
        if (t_dropped !== 8'd2) begin n_fail++; $display("FAIL triple_dropped: got %0d want 2", t_dropped); end
        pulse(1'b0, 1'b1);
        read_px(0, 0);
        n_cmp += 2;
        if (t_rd_data !== 2'd3) begin n_fail++; $display("FAIL triple_newest: got %0d want 3", t_rd_data); end
        if (t_rd_buf !== 2'd1) begin n_fail++; $display("FAIL triple_rd_buf: got %0d want 1", t_rd_buf); end
    endtask

    task automatic test_double();
        do_reset();
        write_px(0, 0, 2'd1);
        pulse(1'b1, 1'b0);
        n_cmp++;
        if (d_wr_ready !== 1'b0) begin n_fail++; $display("FAIL double_not_ready: got %0b want 0", d_wr_ready); end
        write_px(0, 0, 2'd3);
        pulse(1'b1, 1'b0);
        n_cmp += 2;
        if (d_dropped !== 8'd0) begin n_fail++; $display("FAIL double_no_drop: got %0d want 0", d_dropped); end
        if (d_wr_ready !== 1'b0) begin n_fail++; $display("FAIL double_still_blocked: got %0b want 0", d_wr_ready); end
        pulse(1'b0, 1'b1);
        n_cmp += 3;
        if (d_wr_ready !== 1'b1) begin n_fail++; $display("FAIL double_ready: got %0b want 1", d_wr_ready); end
        if (d_rd_buf !== 2'd1) begin n_fail++; $display("FAIL double_rd_buf: got %0d want 1", d_rd_buf); end
        if (d_wr_buf !== 2'd0) begin n_fail++; $display("FAIL double_wr_buf: got %0d want 0", d_wr_buf); end
        read_px(0, 0);
        n_cmp++;
        if (d_rd_data !== 2'd1) begin n_fail++; $display("FAIL double_blocked_write: got %0d want 1", d_rd_data); end
        write_px(0, 0, 2'd2);
        read_px(0, 0);
        n_cmp++;
        if (d_rd_data !== 2'd1) begin n_fail++; $display("FAIL double_display_kept: got %0d want 1", d_rd_data); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        write_px(0, 1, 2'd1);
        write_px(159, 143, 2'd2);
        write_px(160, 0, 2'd3);
        write_px(0, 144, 2'd3);
        pulse(1'b1, 1'b1);
        read_px(0, 1);
        n_cmp += 2;
        if (t_rd_data !== 2'd1) begin n_fail++; $display("FAIL oor_alias: got %0d want 1", t_rd_data); end
        if (t_rd_valid !== 1'b1) begin n_fail++; $display("FAIL oor_alias_valid: got %0b want 1", t_rd_valid); end
        read_px(159, 143);
        n_cmp++;
        if (t_rd_data !== 2'd2) begin n_fail++; $display("FAIL oor_corner: got %0d want 2", t_rd_data); end
        read_px(200, 10);
        n_cmp += 2;
        if (t_rd_data !== 2'd0) begin n_fail++; $display("FAIL oor_read_data: got %0d want 0", t_rd_data); end
        if (t_rd_valid !== 1'b0) begin n_fail++; $display("FAIL oor_read_valid: got %0b want 0", t_rd_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_px(0, 0, 2'd1);
        pulse(1'b1, 1'b1);
        n_cmp += 3;
        if (t_rd_buf !== 2'd1) begin n_fail++; $display("FAIL b2b_rd_buf: got %0d want 1", t_rd_buf); end
        if (t_wr_buf !== 2'd2) begin n_fail++; $display("FAIL b2b_wr_buf: got %0d want 2", t_wr_buf); end
        if (t_dropped !== 8'd0) begin n_fail++; $display("FAIL b2b_no_drop: got %0d want 0", t_dropped); end
        read_px(0, 0);
        n_cmp++;
        if (t_rd_data !== 2'd1) begin n_fail++; $display("FAIL b2b_first: got %0d want 1", t_rd_data); end
        write_px(0, 0, 2'd2);
        pulse(1'b1, 1'b0);
        write_px(0, 0, 2'd3);
        // Read sampled with the swap uses the outgoing reader buffer.
        rd_x = 9'd0; rd_y = 9'd0;
        pulse(1'b1, 1'b1);
        n_cmp += 4;
        if (t_rd_data !== 2'd1) begin n_fail++; $display("FAIL b2b_pre_swap_read: got %0d want 1", t_rd_data); end
        if (t_rd_buf !== 2'd0) begin n_fail++; $display("FAIL b2b_newest_buf: got %0d want 0", t_rd_buf); end
        if (t_wr_buf !== 2'd2) begin n_fail++; $display("FAIL b2b_wr_buf2: got %0d want 2", t_wr_buf); end
        if (t_dropped !== 8'd1) begin n_fail++; $display("FAIL b2b_drop: got %0d want 1", t_dropped); end
        step();
        rd_x = 9'd200; rd_y = 9'd10;
        n_cmp++;
        if (t_rd_data !== 2'd3) begin n_fail++; $display("FAIL b2b_newest_data: got %0d want 3", t_rd_data); end
    endtask

    task automatic test_saturation();
        do_reset();
        wr_frame_done = 1'b1;
        for (int i = 0; i < 300; i++) step();
        wr_frame_done = 1'b0;
        n_cmp++;
        if (t_dropped !== 8'd255) begin n_fail++; $display("FAIL sat_dropped: got %0d want 255", t_dropped); end
        reset_n = 1'b0; wr_en = 1'b1; wr_x = 9'd0; wr_y = 9'd0; wr_data = 2'd3;
        wr_frame_done = 1'b1; rd_frame_start = 1'b1; rd_x = 9'd0; rd_y = 9'd0;
        step();
        reset_n = 1'b1; wr_en = 1'b0; wr_frame_done = 1'b0; rd_frame_start = 1'b0;
        rd_x = 9'd200; rd_y = 9'd10;
        n_cmp += 10;
        if (t_dropped !== 8'd0) begin n_fail++; $display("FAIL sat_reset_dropped: got %0d want 0", t_dropped); end
        if (t_rd_buf !== 2'd0) begin n_fail++; $display("FAIL sat_reset_rd_buf: got %0d want 0", t_rd_buf); end
        if (t_wr_buf !== 2'd1) begin n_fail++; $display("FAIL sat_reset_wr_buf: got %0d want 1", t_wr_buf); end
        if (t_wr_ready !== 1'b1) begin n_fail++; $display("FAIL sat_reset_wr_ready: got %0b want 1", t_wr_ready); end
        if (t_rd_data !== 2'd0) begin n_fail++; $display("FAIL sat_reset_rd_data: got %0d want 0", t_rd_data); end
        if (t_rd_valid !== 1'b0) begin n_fail++; $display("FAIL sat_reset_rd_valid: got %0b want 0", t_rd_valid); end
        if (d_wr_ready !== 1'b1) begin n_fail++; $display("FAIL dbl_reset_wr_ready: got %0b want 1", d_wr_ready); end
        if (d_rd_buf !== 2'd0) begin n_fail++; $display("FAIL dbl_reset_rd_buf: got %0d want 0", d_rd_buf); end
        if (d_wr_buf !== 2'd1) begin n_fail++; $display("FAIL dbl_reset_wr_buf: got %0d want 1", d_wr_buf); end
        if (d_rd_valid !== 1'b0) begin n_fail++; $display("FAIL dbl_reset_rd_valid: got %0b want 0", d_rd_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_triple_drop();
        test_double();
        test_out_of_range();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buffer_multi.md
Name: frame_buffer_multi

Overview:
- Single-clock, parametrised N-buffer (double or triple) frame store between the PPU pixel writer and the VGA/scaler reader.
- Generalises the earlier two-buffer store:
  - configurable resolution, pixel width and buffer count;
  - explicit frame-complete / frame-start handshakes instead of a vblank edge;
  - newest-frame-wins triple buffering;
  - write back-pressure in double mode;
  - out-of-range masking and a dropped-frame counter.

Parameters:
- PIX_BITS, 2, bits per pixel.
- WIDTH, 160, pixels per line.
- HEIGHT, 144, lines per frame.
- COORD_BITS, 9, width of X/Y coordinate inputs.
- NUM_BUFS, 3, buffer count; legal values 2 or 3 only (elaboration error otherwise).

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  pixel write strobe.
- wr_x, wr_y  in  COORD_BITS each  write coordinates.
- wr_data  in  PIX_BITS  pixel value.
- wr_frame_done  in  1  one-cycle pulse: writer finished the current frame.
- wr_ready  out  1  writer may write; low only in double mode while a completed frame awaits the reader.
- rd_x, rd_y  in  COORD_BITS each  read coordinates.
- rd_frame_start  in  1  one-cycle pulse: reader begins a new frame (e.g. VGA vblank end).
- rd_data  out  PIX_BITS  registered pixel.
- rd_valid  out  1  rd_data corresponds to an in-range coordinate.
- wr_buf_idx, rd_buf_idx  out  2 each  current buffer roles, for debug.
- frames_dropped  out  8  saturating count of completed frames overwritten before display.

Behaviour:
Storage and addressing
- NUM_BUFS simple dual-port RAMs, each WIDTH*HEIGHT x PIX_BITS; address = y*WIDTH + x, ceil(log2(WIDTH*HEIGHT)) bits.
- RAM contents are not reset.

Writes
- A write occurs iff wr_en & wr_ready & wr_x<WIDTH & wr_y<HEIGHT, into buffer wr_buf_idx.
- All other writes are silently dropped.

Reads
- Latency 1: rd_data/rd_valid at cycle N+1 reflect rd_x/rd_y and rd_buf_idx sampled at cycle N.
- Out-of-range read -> rd_data=0, rd_valid=0.

Role state
- Registers: rd_buf_idx, wr_buf_idx, spare index (triple only), pending flag.
- Reset: rd_buf_idx=0, wr_buf_idx=1, spare=2, pending=0, wr_ready=1, rd_data=0, rd_valid=0, frames_dropped=0.

wr_frame_done, triple mode
- pending=0: spare <- wr_buf_idx, wr_buf_idx <- old spare, pending=1.
- pending=1: swap wr_buf_idx and spare (newest wins), frames_dropped++ (saturate at 255).

wr_frame_done, double mode
- pending=1, wr_ready=0.
- Ignored if already pending.

rd_frame_start
- pending=1, triple mode: rd_buf_idx <- spare, spare <- old rd_buf_idx, pending=0.
- pending=1, double mode: swap rd_buf_idx and wr_buf_idx, pending=0, wr_ready=1.
- pending=0: no change; reader re-displays the same buffer.

Simultaneous and boundary events
- wr_frame_done and rd_frame_start in the same cycle: apply wr_frame_done first, then rd_frame_start on the resulting state. The just-finished frame is displayed immediately and no drop is counted when pending was 0.
- A write in the same cycle as wr_frame_done lands in the pre-swap write buffer.
- A read sampled in the same cycle as rd_frame_start uses the pre-swap rd_buf_idx; the new index applies from the next cycle.
- Invariant: the three indices are always distinct (triple mode); rd_buf_idx != wr_buf_idx always.
- reset_n low mid-frame: roles, flags and counter return to reset values next edge; write and read strobes in that cycle are ignored.

Test Plan:
1. Reset, write (5,3)=2 into buf1, pulse wr_frame_done then rd_frame_start, read (5,3) -> rd_data=2, rd_valid=1 one cycle after address; rd_buf_idx=1.
2. Triple mode: three wr_frame_done pulses with no rd_frame_start (frames with marker pixel values 1, 2, 3) -> frames_dropped=2; next rd_frame_start displays marker 3.
3. NUM_BUFS=2: wr_frame_done -> wr_ready=0; writes to (0,0)=3 ignored; rd_frame_start -> wr_ready=1, old read buffer becomes writable, (0,0) in displayed buffer unchanged.
4. Out-of-range: write (160,0) and (0,144) -> no RAM change; read (200,10) -> rd_data=0, rd_valid=0.
5. Same-cycle wr_frame_done and rd_frame_start with pending=0 -> new frame displayed, frames_dropped unchanged; with pending=1 (triple) -> newest frame displayed, frames_dropped+1.
6. Saturation: 300 unread completed frames (triple) -> frames_dropped=255; reset_n low one cycle -> all outputs at reset values.
